// File: rtl/sync_count_ctrl.sv
// sync_count_ctrl: run controller for a 4-bit up/down counter.
// A command arrives over a valid/ready handshake and loads start/end/direction/repeat count.
// The block then steps the count modulo 16 from start to end, reps+1 times, and pulses done.
// pause freezes the run, and abort ends it early. The count is exposed on Q1 (LSB) .. Q4 (MSB).
module sync_count_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_start,
    input  logic [3:0] cmd_end,
    input  logic       cmd_up,
    input  logic [3:0] cmd_reps,
    input  logic       pause,
    input  logic       abort,
    output logic       Q1,
    output logic       Q2,
    output logic       Q3,
    output logic       Q4,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] count;
    logic [3:0] start_val;
    logic [3:0] end_val;
    logic       up;
    logic [3:0] rep_left;

    // Decode the handshake and run status straight from state, so that no extra cycle of latency is added.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign Q1 = count[0];
    assign Q2 = count[1];
    assign Q3 = count[2];
    assign Q4 = count[3];

    // Single registered FSM: accepts commands, steps the count and generates the event pulses.
    // NOTE: all state here uses non-blocking (<=) so every register samples pre-edge values;
    // blocking assignments would let later lines see same-cycle updates and break the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 4'd0;
            start_val <= 4'd0;
            end_val   <= 4'd0;
            up        <= 1'b1;
            rep_left  <= 4'd0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            // Pulse outputs default low; each branch raises only what it flags.
            done    <= 1'b0;
            aborted <= 1'b0;
            wrap    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        start_val <= cmd_start;
                        end_val   <= cmd_end;
                        up        <= cmd_up;
                        rep_left  <= cmd_reps;
                        count     <= cmd_start;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else if (pause) begin
                        // Everything holds; wrap already defaulted low.
                    end else if (count == end_val && rep_left == 4'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (count == end_val) begin
                        // Reload for the next pass; a reload never flags wrap.
                        rep_left <= rep_left - 4'd1;
                        count    <= start_val;
                    end else if (up) begin
                        count <= count + 4'd1;
                        wrap  <= (count == 4'd15);
                    end else begin
                        count <= count - 4'd1;
                        wrap  <= (count == 4'd0);
                    end
                end
                DONE: begin
                    // One cycle only; abort is deliberately ignored here.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
